// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu block and its result checker.
//   FP_W            : IEEE-754 single-precision word width
//   OP_*            : fpu opcode encodings
//   ULP_TOL_DEFAULT : default raw bit-pattern distance accepted as a match
//   state_t         : result-checker FSM states
package fpu_pkg;

  localparam int FP_W = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [FP_W-1:0] ULP_TOL_DEFAULT = 32'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_ulp_cmp.sv
// Combinational ULP-distance comparator.
// Ports:
//   exp_val : expected single-precision pattern
//   got_val : observed single-precision pattern
//   tol     : largest accepted raw-pattern distance (unsigned)
//   pass    : 1 when the patterns are within tol of each other
// The distance is taken on the raw 32-bit patterns, modulo 2^32, in both
// directions. NaNs and signs get no special treatment, so a sign mismatch
// is a large distance and fails.
module fpu_ulp_cmp
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] exp_val,
  input  logic [FP_W-1:0] got_val,
  input  logic [FP_W-1:0] tol,
  output logic            pass
);

  logic [FP_W-1:0] d_up;
  logic [FP_W-1:0] d_dn;

  assign d_up = got_val - exp_val;
  assign d_dn = exp_val - got_val;
  assign pass = (d_up <= tol) || (d_dn <= tol);

endmodule

// File: rtl/fpu_result_checker.sv
// Response checker sitting on the fpu result side.
// The fpu driver pushes the expected result in the same cycle it presents
// operands; the checker delays it by FPU_LAT cycles and compares it against
// fpu_o, keeping saturating pass/fail counts and the first failing pair.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : clear counters/capture, flush pipe, enter RUN
//   drain           : stop accepting issues, let in-flight checks finish
//   issue_valid     : operation presented to the fpu this cycle
//   issue_exp       : expected result for that operation
//   issue_ready     : issues are accepted (RUN only)
//   fpu_o           : fpu result output
//   busy            : at least one check in flight
//   done            : all checks complete
//   pass_cnt        : saturating count of passing results
//   fail_cnt        : saturating count of failing results
//   fail_flag       : sticky failure indicator since the last start
//   first_fail_exp  : expected value of the first failure
//   first_fail_got  : observed value of the first failure
module fpu_result_checker
  import fpu_pkg::*;
#(
  parameter int              FPU_LAT = 2,
  parameter logic [FP_W-1:0] TOL     = ULP_TOL_DEFAULT,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             drain,
  input  logic             issue_valid,
  input  logic [FP_W-1:0]  issue_exp,
  output logic             issue_ready,
  input  logic [FP_W-1:0]  fpu_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_flag,
  output logic [FP_W-1:0]  first_fail_exp,
  output logic [FP_W-1:0]  first_fail_got
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t state, state_nxt;

  logic [FPU_LAT-1:0] vld_p;
  logic [FP_W-1:0]    exp_p [FPU_LAT];

  logic            accept;
  logic            tail_vld;
  logic [FP_W-1:0] tail_exp;
  logic            tail_pass;

  assign issue_ready = (state == RUN);
  assign done        = (state == DONE);
  assign busy        = |vld_p;
  assign accept      = issue_valid && issue_ready;
  assign tail_vld    = vld_p[FPU_LAT-1];
  assign tail_exp    = exp_p[FPU_LAT-1];

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    if (drain) state_nxt = DRAIN;
        RUN:     if (drain) state_nxt = DRAIN;
        DRAIN:   if (!busy) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0..p(FPU_LAT-1): alignment pipe, valid bits carry reset.
  // An issue accepted together with start is kept; everything older is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vld_p <= '0;
    end else begin
      state <= state_nxt;
      if (start) vld_p <= FPU_LAT'(accept);
      else       vld_p <= (vld_p << 1) | FPU_LAT'(accept);
    end
  end

  always_ff @(posedge clk) begin
    exp_p[0] <= issue_exp;
    for (int i = 1; i < FPU_LAT; i++) exp_p[i] <= exp_p[i-1];
  end

  fpu_ulp_cmp u_cmp (
    .exp_val (tail_exp),
    .got_val (fpu_o),
    .tol     (TOL),
    .pass    (tail_pass)
  );

  // Pipe tail: verdict folded into counters/capture, visible next cycle.
  // start takes priority, so a compare landing on the start cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      fail_flag      <= 1'b0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else if (tail_vld) begin
      if (tail_pass) begin
        pass_cnt <= sat_inc(pass_cnt);
      end else begin
        fail_cnt <= sat_inc(fail_cnt);
        if (!fail_flag) begin
          fail_flag      <= 1'b1;
          first_fail_exp <= tail_exp;
          first_fail_got <= fpu_o;
        end
      end
    end
  end

endmodule

// File: doc/fpu_result_checker.md
Name: fpu_result_checker

Overview:
Synthesizable response checker on the far end of the fpu operand/result interface. Whoever drives the fpu (sequencer, BIST, or host) pushes the expected result into this block in the same cycle it presents A/B/opcode. The block aligns each expected value with the fpu latency and compares it against fpu O within an ULP tolerance. It keeps pass/fail counts and captures the first failure, so long FPU regressions run on silicon or FPGA without a simulator bench.

Parameters:
FPU_LAT, 2, cycles from operand presentation to valid O on the fpu (1..8)
TOL, 2, max raw bit-pattern distance accepted as a pass (unsigned, modulo 2^32)
CNT_W, 16, width of pass/fail counters

Ports:
clk  in  1  system clock (same clock as fpu)
rst  in  1  synchronous, active-high reset
start  in  1  pulse: clear counters and capture regs, enter RUN
drain  in  1  pulse: stop accepting issues, finish in-flight checks
issue_valid  in  1  an operation is presented to the fpu this cycle
issue_exp  in  32  expected IEEE-754 single result for that operation
issue_ready  out  1  checker accepts issues (high only in RUN)
fpu_o  in  32  fpu O output
busy  out  1  at least one check in flight
done  out  1  all checks complete (DONE state)
pass_cnt  out  CNT_W  number of passing results, saturating
fail_cnt  out  CNT_W  number of failing results, saturating
fail_flag  out  1  sticky: any failure since last start
first_fail_exp  out  32  expected value of first failure
first_fail_got  out  32  fpu_o of first failure

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; all pipe valid bits cleared; issue_ready=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, fail_flag=0, first_fail_exp=0, first_fail_got=0. Reset mid-run discards in-flight checks silently.
- FSM: IDLE -start-> RUN; RUN -drain-> DRAIN; DRAIN -(pipe empty)-> DONE; DONE -start-> RUN. In any state, start clears counters, flag, and capture regs, flushes the pipe, and enters RUN. start wins over a simultaneous drain.
- Issue accepted iff issue_valid && issue_ready. issue_ready=1 only in RUN, and it is combinational from state. issue_valid outside RUN is ignored and never counted.
- Alignment: {valid, exp} shift pipe of depth FPU_LAT. An issue accepted in cycle t is compared against fpu_o sampled in cycle t+FPU_LAT. Back-to-back issues every cycle are supported with no bubbles.
- Compare (combinational at the pipe tail): d1=(fpu_o-exp) mod 2^32, d2=(exp-fpu_o) mod 2^32. Pass iff d1<=TOL or d2<=TOL. This is raw-pattern distance: no NaN or sign special-casing, so a sign mismatch fails.
- Counters and capture update at the end of the compare cycle and are visible in cycle t+FPU_LAT+1. Counters saturate at 2^CNT_W-1.
- The first failure after start sets fail_flag and loads first_fail_exp/got. Later failures only increment fail_cnt.
- busy = OR of pipe valid bits. DRAIN to DONE happens in the cycle after busy is 0. done=1 only in DONE. drain in IDLE goes straight to DONE through DRAIN with an empty pipe, taking 2 cycles.
- drain in the same cycle as an accepted issue: the issue is kept and checked.

Decomposition:
- Shared package fpu_pkg: FP_W=32; opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10, OP_MUL=2'b11; default ULP tolerance 2; FSM state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module: fpu_ulp_cmp. It is combinational, takes exp, got and TOL, and returns pass. The fpu bench reuses it.

Test Plan:
- Reset, start, one issue exp=0xA7CD85A9, fpu_o=0xA7CD85A9 at t+2 -> pass_cnt=1 at t+3, fail_cnt=0, done=1 two cycles after drain.
- exp=0x474C6719, fpu_o=0x474C671B (+2) and then fpu_o=0x474C6717 (-2) -> both pass, pass_cnt=2.
- exp=0x474C6719, fpu_o=0x474C671C (+3) -> fail_cnt=1, fail_flag=1, first_fail_exp=0x474C6719, first_fail_got=0x474C671C. A second failure with got=0 leaves the capture unchanged.
- Four back-to-back issues (0xA7CD85A9, 0x474C6719, 0xE75B6451, 0xC93B51C5) with matching fpu_o stream -> pass_cnt=4. busy is high from the cycle after the first issue until 2 cycles after the last.
- issue_valid held high in IDLE and DONE -> issue_ready=0, counters unchanged.
- rst asserted while two checks are in flight -> next cycle all outputs 0, state IDLE. The stale fpu_o is never counted.
